// File: rtl/udp_rx_parse.sv
// UDP receive parser: strips the 8-byte UDP header from the IP RX stream and forwards the payload.
// state   | meaning
// IDLE    | waiting for ip_rx_start
// HDR     | capturing header bytes 0-7
// DATA    | forwarding payload bytes, one cycle late
// DISCARD | swallowing bytes until the IP last byte
module udp_rx_parse #(
    parameter logic [7:0] UDP_PROTO = 8'd17,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ip_rx_start,
    input  logic             ip_rx_hdr_is_valid,
    input  logic [7:0]       ip_rx_hdr_protocol,
    input  logic [15:0]      ip_rx_hdr_data_length,
    input  logic [31:0]      ip_rx_hdr_src_ip_addr,
    input  logic [7:0]       ip_rx_data_in,
    input  logic             ip_rx_data_in_valid,
    input  logic             ip_rx_data_in_last,
    output logic             udp_rx_start,
    output logic             udp_rxi_hdr_is_valid,
    output logic [31:0]      udp_rxi_hdr_src_ip_addr,
    output logic [15:0]      udp_rxi_hdr_src_port,
    output logic [15:0]      udp_rxi_hdr_dst_port,
    output logic [15:0]      udp_rxi_hdr_data_length,
    output logic [7:0]       udp_rxi_data_in,
    output logic             udp_rxi_data_in_valid,
    output logic             udp_rxi_data_in_last,
    output logic [CNT_W-1:0] udp_rx_drop_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_DATA    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]      r_src_ip;
    logic [15:0]      r_ip_len;
    logic [2:0]       r_hdr_idx;
    logic [15:0]      r_src_port;
    logic [15:0]      r_dst_port;
    logic [15:0]      r_udp_len;
    logic [15:0]      r_pay_cnt;

    logic             r_start;
    logic             r_hdr_valid;
    logic [31:0]      r_hdr_src_ip;
    logic [15:0]      r_hdr_src_port;
    logic [15:0]      r_hdr_dst_port;
    logic [15:0]      r_hdr_len;
    logic [7:0]       r_data;
    logic             r_data_valid;
    logic             r_data_last;
    logic [CNT_W-1:0] r_drop_cnt;

    logic       w_can_start;
    logic       w_start_ok;
    logic       w_hdr_take;
    logic [2:0] w_hdr_idx;
    logic       w_hdr_end;
    logic       w_len_ok;
    logic       w_pay_zero;
    logic       w_pay_reach;
    logic       w_in_last;
    logic       w_go;
    logic       w_drop;
    logic       w_fwd;
    logic       w_fwd_last;

    // A start in DISCARD abandons the datagram being swallowed.
    assign w_can_start = ip_rx_start && ((r_state == S_IDLE) || (r_state == S_DISCARD));
    assign w_start_ok  = ip_rx_hdr_is_valid && (ip_rx_hdr_protocol == UDP_PROTO)
                         && (ip_rx_hdr_data_length >= 16'd8);
    assign w_hdr_take  = ip_rx_data_in_valid && ((r_state == S_HDR) || (w_can_start && w_start_ok));
    assign w_hdr_idx   = w_can_start ? 3'd0 : r_hdr_idx;
    assign w_hdr_end   = w_hdr_take && (w_hdr_idx == 3'd7);
    assign w_len_ok    = (r_udp_len >= 16'd8) && (r_udp_len <= r_ip_len);
    assign w_pay_zero  = (r_udp_len == 16'd8);
    assign w_pay_reach = ((r_pay_cnt + 16'd1) == r_hdr_len);
    assign w_in_last   = ip_rx_data_in_valid && ip_rx_data_in_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DISCARD: begin
                if (ip_rx_start) begin
                    if (w_in_last)       w_state_nxt = S_IDLE;
                    else if (!w_start_ok) w_state_nxt = S_DISCARD;
                    else                 w_state_nxt = S_HDR;
                end else if ((r_state == S_DISCARD) && w_in_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HDR: begin
                if (ip_rx_data_in_valid) begin
                    if (ip_rx_data_in_last) w_state_nxt = S_IDLE;
                    else if (w_hdr_end)     w_state_nxt = (w_len_ok && !w_pay_zero) ? S_DATA : S_DISCARD;
                end
            end
            S_DATA: begin
                if (ip_rx_data_in_valid) begin
                    if (w_pay_reach)             w_state_nxt = ip_rx_data_in_last ? S_IDLE : S_DISCARD;
                    else if (ip_rx_data_in_last) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_go       = 1'b0;
        w_drop     = 1'b0;
        w_fwd      = 1'b0;
        w_fwd_last = 1'b0;
        case (r_state)
            S_IDLE, S_DISCARD: begin
                if (ip_rx_start && (!w_start_ok || w_in_last)) w_drop = 1'b1;
            end
            S_HDR: begin
                if (ip_rx_data_in_valid) begin
                    if (w_hdr_end) begin
                        if (w_len_ok) begin
                            w_go = 1'b1;
                            // IP stream ended right after the header although payload was promised
                            if (!w_pay_zero && ip_rx_data_in_last) w_drop = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else if (ip_rx_data_in_last) begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (ip_rx_data_in_valid) begin
                    w_fwd = 1'b1;
                    if (w_pay_reach) begin
                        w_fwd_last = 1'b1;
                    end else if (ip_rx_data_in_last) begin
                        w_fwd_last = 1'b1;
                        w_drop     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ip       <= '0;
            r_ip_len       <= '0;
            r_hdr_idx      <= '0;
            r_src_port     <= '0;
            r_dst_port     <= '0;
            r_udp_len      <= '0;
            r_pay_cnt      <= '0;
            r_start        <= 1'b0;
            r_hdr_valid    <= 1'b0;
            r_hdr_src_ip   <= '0;
            r_hdr_src_port <= '0;
            r_hdr_dst_port <= '0;
            r_hdr_len      <= '0;
            r_data         <= '0;
            r_data_valid   <= 1'b0;
            r_data_last    <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            r_start      <= w_go;
            r_data_valid <= w_fwd;
            r_data_last  <= w_fwd_last;
            if (w_fwd) r_data <= ip_rx_data_in;

            if (w_can_start) begin
                r_src_ip <= ip_rx_hdr_src_ip_addr;
                r_ip_len <= ip_rx_hdr_data_length;
            end

            if (w_hdr_take) begin
                r_hdr_idx <= w_hdr_idx + 3'd1;
                case (w_hdr_idx)
                    3'd0: r_src_port[15:8] <= ip_rx_data_in;
                    3'd1: r_src_port[7:0]  <= ip_rx_data_in;
                    3'd2: r_dst_port[15:8] <= ip_rx_data_in;
                    3'd3: r_dst_port[7:0]  <= ip_rx_data_in;
                    3'd4: r_udp_len[15:8]  <= ip_rx_data_in;
                    3'd5: r_udp_len[7:0]   <= ip_rx_data_in;
                    default: ;
                endcase
            end else if (w_can_start) begin
                r_hdr_idx <= 3'd0;
            end

            if (w_go) begin
                r_hdr_valid    <= 1'b1;
                r_hdr_src_ip   <= r_src_ip;
                r_hdr_src_port <= r_src_port;
                r_hdr_dst_port <= r_dst_port;
                r_hdr_len      <= r_udp_len - 16'd8;
                r_pay_cnt      <= '0;
            end else if (w_fwd) begin
                r_pay_cnt <= r_pay_cnt + 16'd1;
            end

            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign udp_rx_start            = r_start;
    assign udp_rxi_hdr_is_valid    = r_hdr_valid;
    assign udp_rxi_hdr_src_ip_addr = r_hdr_src_ip;
    assign udp_rxi_hdr_src_port    = r_hdr_src_port;
    assign udp_rxi_hdr_dst_port    = r_hdr_dst_port;
    assign udp_rxi_hdr_data_length = r_hdr_len;
    assign udp_rxi_data_in         = r_data;
    assign udp_rxi_data_in_valid   = r_data_valid;
    assign udp_rxi_data_in_last    = r_data_last;
    assign udp_rx_drop_count       = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_parse.sv
// Scoreboard bench for udp_rx_parse: directed datagrams followed by randomized traffic.
module tb_udp_rx_parse;

    logic        clk = 1'b0;
    logic        reset;
    logic        ip_rx_start;
    logic        ip_rx_hdr_is_valid;
    logic [7:0]  ip_rx_hdr_protocol;
    logic [15:0] ip_rx_hdr_data_length;
    logic [31:0] ip_rx_hdr_src_ip_addr;
    logic [7:0]  ip_rx_data_in;
    logic        ip_rx_data_in_valid;
    logic        ip_rx_data_in_last;

    logic        udp_rx_start;
    logic        udp_rxi_hdr_is_valid;
    logic [31:0] udp_rxi_hdr_src_ip_addr;
    logic [15:0] udp_rxi_hdr_src_port;
    logic [15:0] udp_rxi_hdr_dst_port;
    logic [15:0] udp_rxi_hdr_data_length;
    logic [7:0]  udp_rxi_data_in;
    logic        udp_rxi_data_in_valid;
    logic        udp_rxi_data_in_last;
    logic [15:0] udp_rx_drop_count;

    logic        s_start, s_hv, s_dv, s_dl;
    logic [31:0] s_ip;
    logic [15:0] s_sp, s_dp, s_len;
    logic [7:0]  s_d;
    logic [1:0]  s_drop;

    udp_rx_parse u_dut (
        .clk(clk), .reset(reset), .ip_rx_start(ip_rx_start),
        .ip_rx_hdr_is_valid(ip_rx_hdr_is_valid), .ip_rx_hdr_protocol(ip_rx_hdr_protocol),
        .ip_rx_hdr_data_length(ip_rx_hdr_data_length), .ip_rx_hdr_src_ip_addr(ip_rx_hdr_src_ip_addr),
        .ip_rx_data_in(ip_rx_data_in), .ip_rx_data_in_valid(ip_rx_data_in_valid),
        .ip_rx_data_in_last(ip_rx_data_in_last), .udp_rx_start(udp_rx_start),
        .udp_rxi_hdr_is_valid(udp_rxi_hdr_is_valid), .udp_rxi_hdr_src_ip_addr(udp_rxi_hdr_src_ip_addr),
        .udp_rxi_hdr_src_port(udp_rxi_hdr_src_port), .udp_rxi_hdr_dst_port(udp_rxi_hdr_dst_port),
        .udp_rxi_hdr_data_length(udp_rxi_hdr_data_length), .udp_rxi_data_in(udp_rxi_data_in),
        .udp_rxi_data_in_valid(udp_rxi_data_in_valid), .udp_rxi_data_in_last(udp_rxi_data_in_last),
        .udp_rx_drop_count(udp_rx_drop_count)
    );

    udp_rx_parse #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .ip_rx_start(ip_rx_start),
        .ip_rx_hdr_is_valid(ip_rx_hdr_is_valid), .ip_rx_hdr_protocol(ip_rx_hdr_protocol),
        .ip_rx_hdr_data_length(ip_rx_hdr_data_length), .ip_rx_hdr_src_ip_addr(ip_rx_hdr_src_ip_addr),
        .ip_rx_data_in(ip_rx_data_in), .ip_rx_data_in_valid(ip_rx_data_in_valid),
        .ip_rx_data_in_last(ip_rx_data_in_last), .udp_rx_start(s_start),
        .udp_rxi_hdr_is_valid(s_hv), .udp_rxi_hdr_src_ip_addr(s_ip),
        .udp_rxi_hdr_src_port(s_sp), .udp_rxi_hdr_dst_port(s_dp),
        .udp_rxi_hdr_data_length(s_len), .udp_rxi_data_in(s_d),
        .udp_rxi_data_in_valid(s_dv), .udp_rxi_data_in_last(s_dl),
        .udp_rx_drop_count(s_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ip;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [15:0] len;
        int          cyc;
    } hdr_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         cyc;
    } beat_t;

    hdr_t       exp_hdr[$];
    beat_t      exp_beat[$];
    hdr_t       last_hdr;
    logic       hdr_seen;
    logic [7:0] pkt[$];
    int         model_drop;
    int         n_vec = 0;
    int         n_err = 0;

    logic        g_hv;
    logic [7:0]  g_proto;
    logic [15:0] g_len;
    logic [31:0] g_ip;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every start pulse and every payload beat must match the head of its queue.
    always @(negedge clk) begin
        hdr_t  h;
        beat_t b;
        if (!reset) begin
            if (udp_rx_start) begin
                if (exp_hdr.size() == 0) begin
                    check("unexpected_start", {udp_rxi_hdr_src_port, udp_rxi_hdr_dst_port}, 128'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    h = exp_hdr.pop_front();
                    check("hdr_fields",
                          {udp_rxi_hdr_is_valid, udp_rxi_hdr_src_ip_addr, udp_rxi_hdr_src_port,
                           udp_rxi_hdr_dst_port, udp_rxi_hdr_data_length, 32'(cyc)},
                          {1'b1, h.ip, h.sp, h.dp, h.len, 32'(h.cyc)});
                end
            end
            if (udp_rxi_data_in_valid) begin
                if (exp_beat.size() == 0) begin
                    check("unexpected_beat", {udp_rxi_data_in, udp_rxi_data_in_last}, 128'hFFFF_FFFF);
                end else begin
                    b = exp_beat.pop_front();
                    check("payload_beat", {udp_rx_start, udp_rxi_data_in, udp_rxi_data_in_last, 32'(cyc)},
                          {1'b0, b.d, b.last, 32'(b.cyc)});
                end
            end else if (udp_rxi_data_in_last) begin
                check("last_without_valid", 128'(udp_rxi_data_in_last), 128'd0);
            end
        end
    end

    // Reference: what a datagram of n bytes (last on byte n-1) should produce.
    task automatic model_dgram(input logic hv, input logic [7:0] proto, input logic [15:0] iplen, input int n,
                               output bit hok, output int k, output bit drop);
        int udp, pay, avail;
        hok = 0; k = 0; drop = 0;
        if (!hv || proto != 8'd17 || iplen < 8 || n < 8) begin
            drop = 1;
            return;
        end
        udp = int'({pkt[4], pkt[5]});
        if (udp < 8 || udp > int'(iplen)) begin
            drop = 1;
            return;
        end
        hok   = 1;
        pay   = udp - 8;
        avail = n - 8;
        k     = (pay < avail) ? pay : avail;
        drop  = (avail < pay);
    endtask

    task automatic drive(input bit st, input bit v, input logic [7:0] d, input bit l);
        ip_rx_start           = st;
        ip_rx_data_in_valid   = v;
        ip_rx_data_in         = v ? d : 8'($urandom);
        ip_rx_data_in_last    = v ? l : 1'($urandom);
        ip_rx_hdr_is_valid    = st ? g_hv    : 1'($urandom);
        ip_rx_hdr_protocol    = st ? g_proto : 8'($urandom);
        ip_rx_hdr_data_length = st ? g_len   : 16'($urandom);
        ip_rx_hdr_src_ip_addr = st ? g_ip    : 32'($urandom);
        @(posedge clk);
        #1;
        ip_rx_start         = 1'b0;
        ip_rx_data_in_valid = 1'b0;
        ip_rx_data_in_last  = 1'b0;
    endtask

    task automatic fill_pkt(input int n, input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] udp);
        logic [47:0] hb;
        hb = {sp, dp, udp};
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
        for (int i = 0; i < 6 && i < n; i++) pkt[i] = hb[47 - 8*i -: 8];
    endtask

    task automatic send_dgram(input logic hv, input logic [7:0] proto, input logic [15:0] iplen,
                              input logic [31:0] sip, input int n, input int stop_at,
                              input int gap_lo, input int gap_hi, input bit with_b0);
        bit   hok, drop;
        int   k;
        hdr_t h;
        beat_t b;
        model_dgram(hv, proto, iplen, n, hok, k, drop);
        if (drop) model_drop++;
        g_hv = hv; g_proto = proto; g_len = iplen; g_ip = sip;
        if (!with_b0) drive(1, 0, 8'h00, 0);
        for (int i = 0; i < stop_at; i++) begin
            if (i > 0 || !with_b0) repeat ($urandom_range(gap_hi, gap_lo)) drive(0, 0, 8'h00, 0);
            if (hok && i == 7) begin
                h.ip = sip; h.sp = {pkt[0], pkt[1]}; h.dp = {pkt[2], pkt[3]};
                h.len = {pkt[4], pkt[5]} - 16'd8; h.cyc = cyc + 1;
                exp_hdr.push_back(h);
                last_hdr = h;
                hdr_seen = 1'b1;
            end
            if (hok && i >= 8 && i < 8 + k) begin
                b.d = pkt[i]; b.last = (i == 8 + k - 1); b.cyc = cyc + 1;
                exp_beat.push_back(b);
            end
            drive(with_b0 && i == 0, 1, pkt[i], i == n - 1);
        end
    endtask

    task automatic end_check(input string tag);
        repeat (4) drive(0, 0, 8'h00, 0);
        check({tag, "_drop"}, 128'(udp_rx_drop_count), 128'(model_drop > 65535 ? 65535 : model_drop));
        check({tag, "_drop_sat"}, 128'(s_drop), 128'(model_drop > 3 ? 3 : model_drop));
        check({tag, "_pending"}, 128'({exp_hdr.size(), exp_beat.size()}), 128'd0);
        check({tag, "_hold"},
              {udp_rxi_hdr_is_valid, udp_rxi_hdr_src_ip_addr, udp_rxi_hdr_src_port,
               udp_rxi_hdr_dst_port, udp_rxi_hdr_data_length},
              hdr_seen ? {1'b1, last_hdr.ip, last_hdr.sp, last_hdr.dp, last_hdr.len} : 128'd0);
        repeat ($urandom_range(2, 0)) drive(0, 1, 8'($urandom), 1'($urandom));
    endtask

    task automatic clear_model();
        exp_hdr.delete();
        exp_beat.delete();
        model_drop = 0;
        hdr_seen   = 1'b0;
        last_hdr   = '{32'd0, 16'd0, 16'd0, 16'd0, 0};
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({udp_rx_start, udp_rxi_hdr_is_valid, udp_rxi_hdr_src_ip_addr, udp_rxi_hdr_src_port,
                     udp_rxi_hdr_dst_port, udp_rxi_hdr_data_length, udp_rxi_data_in,
                     udp_rxi_data_in_valid, udp_rxi_data_in_last, udp_rx_drop_count});
    endfunction

    task automatic nominal(input bit with_b0);
        fill_pkt(12, 16'd1234, 16'd80, 16'd12);
        pkt[6] = 8'h00; pkt[7] = 8'h00;
        pkt[8] = 8'hDE; pkt[9] = 8'hAD; pkt[10] = 8'hBE; pkt[11] = 8'hEF;
    endtask

    initial begin
        int t, iplen, udp, n;
        logic hv;
        logic [7:0] proto;

        reset = 1'b1;
        ip_rx_start = 0; ip_rx_data_in_valid = 0; ip_rx_data_in_last = 0; ip_rx_data_in = 0;
        ip_rx_hdr_is_valid = 0; ip_rx_hdr_protocol = 0; ip_rx_hdr_data_length = 0; ip_rx_hdr_src_ip_addr = 0;
        g_hv = 0; g_proto = 0; g_len = 0; g_ip = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", all_outputs(), 128'd0);
        reset = 1'b0;

        nominal(0);
        send_dgram(1, 8'd17, 16'd12, 32'hC0A8_0001, 12, 12, 0, 0, 0);
        end_check("nominal");

        fill_pkt(20, 16'h1111, 16'h2222, 16'd20);
        send_dgram(1, 8'd6, 16'd20, 32'h0A00_0002, 20, 20, 0, 0, 1);
        end_check("non_udp");

        fill_pkt(46, 16'd5000, 16'd6000, 16'd18);
        send_dgram(1, 8'd17, 16'd46, 32'h0A00_0003, 46, 46, 0, 0, 1);
        end_check("padding");

        fill_pkt(6, 16'd7, 16'd9, 16'd20);
        send_dgram(1, 8'd17, 16'd20, 32'h0A00_0004, 6, 6, 0, 0, 0);
        end_check("trunc_hdr");

        fill_pkt(16, 16'd77, 16'd99, 16'd20);
        send_dgram(1, 8'd17, 16'd20, 32'h0A00_0005, 16, 16, 0, 0, 1);
        end_check("trunc_payload");

        fill_pkt(8, 16'd53, 16'd54, 16'd8);
        send_dgram(1, 8'd17, 16'd8, 32'h0A00_0006, 8, 8, 0, 0, 1);
        end_check("zero_payload");

        fill_pkt(12, 16'd100, 16'd200, 16'd12);
        send_dgram(1, 8'd17, 16'd12, 32'h0A00_0007, 12, 12, 1, 1, 1);
        end_check("gaps");

        // Abandon a datagram by reset after its third payload byte.
        nominal(1);
        send_dgram(1, 8'd17, 16'd12, 32'h0A00_0008, 12, 11, 0, 0, 1);
        drive(0, 0, 8'h00, 0);
        reset = 1'b1;
        drive(0, 1, 8'hEF, 1);
        check("reset_mid_dgram", all_outputs(), 128'd0);
        reset = 1'b0;
        clear_model();
        drive(0, 1, 8'hEF, 1);
        end_check("after_reset");
        nominal(0);
        send_dgram(1, 8'd17, 16'd12, 32'h0A00_0009, 12, 12, 0, 0, 0);
        end_check("reparse");

        fill_pkt(10, 16'd1, 16'd2, 16'd10);
        send_dgram(0, 8'd17, 16'd10, 32'h1, 10, 10, 0, 0, 1);
        end_check("bad_valid");
        fill_pkt(10, 16'd1, 16'd2, 16'd10);
        send_dgram(1, 8'd6, 16'd10, 32'h2, 10, 10, 0, 0, 0);
        end_check("bad_proto");
        fill_pkt(5, 16'd1, 16'd2, 16'd5);
        send_dgram(1, 8'd17, 16'd5, 32'h3, 5, 5, 0, 0, 1);
        end_check("bad_iplen");
        fill_pkt(12, 16'd1, 16'd2, 16'd4);
        send_dgram(1, 8'd17, 16'd12, 32'h4, 12, 12, 0, 0, 0);
        end_check("bad_udplen");

        for (int r = 0; r < 60; r++) begin
            t = $urandom_range(5, 0);
            hv = 1'b1; proto = 8'd17;
            iplen = $urandom_range(40, 9);
            udp = $urandom_range(iplen, 8);
            n = iplen;
            case (t)
                1: begin
                    case ($urandom_range(2, 0))
                        0: hv = 1'b0;
                        1: begin proto = 8'($urandom); if (proto == 8'd17) proto = 8'd6; end
                        default: iplen = $urandom_range(7, 0);
                    endcase
                    n = $urandom_range(12, 1);
                end
                2: udp = ($urandom_range(1, 0) == 1) ? $urandom_range(7, 0) : iplen + $urandom_range(10, 1);
                3: n = $urandom_range(iplen - 1, 1);
                default: ;
            endcase
            fill_pkt(n, 16'($urandom), 16'($urandom), 16'(udp));
            send_dgram(hv, proto, 16'(iplen), $urandom, n, n, 0, $urandom_range(2, 0), 1'($urandom));
            end_check("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/udp_rx_parse.md
# udp_rx_parse

Receive-side UDP layer: consumes the IP-layer RX byte stream, parses the 8-byte UDP header, and presents header fields plus a byte-wide user payload stream to the application. It is the counterpart of the UDP TX path: it sits between the IPv4 RX block and the application-side `udp_rxi` consumer. The UDP checksum is not verified. Non-UDP, malformed and truncated datagrams are dropped and counted.

## Interface
Parameters:
- `UDP_PROTO`, 8'd17, IP protocol number accepted as UDP.
- `CNT_W`, 16, width of the drop counter.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ip_rx_start`  in  1  one-cycle pulse; the IP header fields are valid in this cycle.
- `ip_rx_hdr_is_valid`  in  1  IP header passed IP-layer checks.
- `ip_rx_hdr_protocol`  in  8  IP protocol field.
- `ip_rx_hdr_data_length`  in  16  IP payload length in bytes.
- `ip_rx_hdr_src_ip_addr`  in  32  source IP address.
- `ip_rx_data_in`  in  8  IP payload byte.
- `ip_rx_data_in_valid`  in  1  byte qualifier.
- `ip_rx_data_in_last`  in  1  last IP payload byte; qualified by valid.
- `udp_rx_start`  out  1  one-cycle pulse when the UDP header fields are valid.
- `udp_rxi_hdr_is_valid`  out  1  accepted datagram.
- `udp_rxi_hdr_src_ip_addr`  out  32  source IP address.
- `udp_rxi_hdr_src_port`  out  16  UDP source port.
- `udp_rxi_hdr_dst_port`  out  16  UDP destination port.
- `udp_rxi_hdr_data_length`  out  16  payload bytes, equal to UDP length − 8.
- `udp_rxi_data_in`  out  8  payload byte.
- `udp_rxi_data_in_valid`  out  1  payload byte qualifier.
- `udp_rxi_data_in_last`  out  1  final payload byte.
- `udp_rx_drop_count`  out  CNT_W  saturating count of dropped datagrams.

## Operation
- FSM states: IDLE, HDR, DATA, DISCARD.
- **IDLE**
  - On `ip_rx_start`, latch src IP, IP length, protocol and is_valid; clear the byte counter; go to HDR.
  - If `ip_rx_hdr_is_valid`=0, or the protocol ≠ `UDP_PROTO`, or the IP length is below 8: go to DISCARD instead, and increment the drop counter.
  - A valid byte in the same cycle as `ip_rx_start` is accepted as byte 0.
  - Valid bytes in IDLE without `ip_rx_start` are ignored.
- **HDR**
  - Capture bytes 0–7, big-endian: src port [0:1], dst port [2:3], UDP length [4:5], checksum [6:7] (discarded).
  - After byte 7 is accepted:
    - If 8 ≤ UDP length ≤ IP length: pulse `udp_rx_start` with the header valid and `is_valid`=1.
      - If the payload length is 0, go to DISCARD, or to IDLE if byte 7 carried `last`.
      - Otherwise go to DATA.
    - If UDP length is below 8 or exceeds the IP length: drop, with no start pulse, and go to DISCARD.
  - `ip_rx_data_in_last` before byte 7: truncated header. Drop, no start pulse, go to IDLE.
- **DATA**
  - Forward each valid input byte, registered.
  - Assert `udp_rxi_data_in_last` on the byte where the payload count reaches `data_length`.
  - If the input `last` arrives first, assert `last` on that byte, increment the drop counter, and go to IDLE.
  - When the count is reached:
    - If the input `last` is set on that byte, go to IDLE.
    - Otherwise go to DISCARD (IP padding).
- **DISCARD**
  - Consume bytes without output until `ip_rx_data_in_last`, then go to IDLE.
  - An `ip_rx_start` seen here is treated as a new datagram (previous one abandoned).
- Drop counter saturates at all-ones; it never wraps.
- Header outputs hold their value until the next `udp_rx_start` or reset.

## Timing
- Reset values: all outputs 0, FSM in IDLE, drop counter 0. Reset mid-datagram abandons it with no `last` emitted; bytes arriving before the next `ip_rx_start` are ignored.
- `udp_rx_start` is asserted in the cycle after UDP header byte 7 is accepted, for exactly one cycle. Header outputs are valid from that same cycle.
- Payload latency is one cycle, input byte to output byte. `udp_rxi_data_in_valid` mirrors the input valid gaps; there is no backpressure.
- The first payload byte is never output in the same cycle as `udp_rx_start`. It appears at the earliest one cycle after the start pulse.
- `last` and `valid` are asserted together, for one cycle.
- The drop counter updates in the cycle after the drop decision.

## Test plan
- **Nominal datagram**: IP proto 17, length 12; bytes 0x04 0xD2 0x00 0x50 0x00 0x0C 0x00 0x00 0xDE 0xAD 0xBE 0xEF with last on the final byte.
  - Start pulse with src port 1234, dst port 80, data_length 4.
  - Output DE AD BE EF, `last` on EF; drop counter stays 0.
- **Non-UDP**: proto 6, 20 bytes. No start pulse, no output bytes, drop counter = 1, FSM back in IDLE after `last`.
- **Padding**: IP length 46, UDP length 18. Exactly 10 payload bytes output, `last` on the 10th; remaining 28 bytes discarded, no drop.
- **Truncation**
  - Input `last` at byte 5: no start pulse, drop counter +1.
  - UDP length 20 but input `last` at byte 15: 8 payload bytes output with `last` on the 8th; drop counter +1.
- **Zero payload and gaps**
  - UDP length 8: start pulse with data_length 0, no data beats.
  - 4-byte payload with one idle cycle between each byte: the same gaps appear on the output, each byte one cycle late.
- **Reset and saturation**
  - Reset asserted after payload byte 2: all outputs 0 next cycle, no `last`; the next datagram is parsed correctly.
  - With `CNT_W`=2, four bad datagrams leave the counter at 3.
